tx_request_arbiter: RTL and testbench

- Shares one serial message transmitter among N_REQ requesters.
- The transmitter takes send, message[4:0], mode, cnt[2:0] and drives GPIO.
- Latches the winning requester's frame fields, sequences the transmitter's send strobe, tracks its busy flag and enforces an inter-frame gap.
- Returns a one-cycle ack to the owner when its frame has finished.

---
 rtl/tx_arb_pkg.sv | 25 ++
 rtl/tx_request_arbiter_rr_pick.sv | 38 +++
 rtl/tx_request_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_tx_request_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared widths, FSM state encoding and a pointer helper for the
// transmitter request arbiter.
package tx_arb_pkg;

   localparam int MSG_W   = 5;
   localparam int CNT_W   = 3;
   localparam int OWNER_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } state_e;

   // Index following idx, wrapping to 0 after n-1.
   function automatic logic [OWNER_W-1:0] next_index(input logic [OWNER_W-1:0] idx,
                                                     input int unsigned        n);
      logic [OWNER_W-1:0] nxt;
      if (32'(idx) + 32'd1 >= n) nxt = '0;
      else                       nxt = idx + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/tx_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// the pointer, wrapping modulo N_REQ.
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0]   eligible,
   input  logic [OWNER_W-1:0] pointer,
   output logic               found,
   output logic [OWNER_W-1:0] index
);

   localparam logic [OWNER_W:0] N_W = (OWNER_W + 1)'(N_REQ);

   logic [2*N_REQ-1:0] doubled;
   logic [N_REQ-1:0]   rotated;
   logic [OWNER_W:0]   sum_c;

   // Rotating the doubled vector puts the pointer's requester at bit 0.
   assign doubled = {eligible, eligible};
   assign rotated = N_REQ'(doubled >> pointer);

   always_comb begin
      found = 1'b0;
      index = '0;
      sum_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found && rotated[i]) begin
            found = 1'b1;
            sum_c = {1'b0, pointer} + (OWNER_W + 1)'(i);
            if (sum_c >= N_W) sum_c = sum_c - N_W;
            index = sum_c[OWNER_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tx_request_arbiter.sv
// Shares one serial message transmitter among N_REQ requesters with an
// inter-frame gap. Optional watchdog abort enabled by TX_ARB_TIMEOUT_EN.
module tx_request_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_REQ          = 3,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [MSG_W*N_REQ-1:0] msg_in,
   input  logic [N_REQ-1:0]       mode_in,
   input  logic [CNT_W*N_REQ-1:0] cnt_in,
   output logic [N_REQ-1:0]       ack,
   output logic                   err,
   output logic [OWNER_W-1:0]     owner,
   output logic                   active,
   output logic                   tx_send,
   output logic [MSG_W-1:0]       tx_message,
   output logic                   tx_mode,
   output logic [CNT_W-1:0]       tx_cnt,
   input  logic                   tx_busy
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [N_REQ-1:0] ACK_LSB = N_REQ'(1);

   if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("tx_request_arbiter: parameter out of range");
   end

   state_e             state_q;
   logic [OWNER_W-1:0] ptr_q;
   logic [OWNER_W-1:0] ptr_d;
   logic [OWNER_W-1:0] owner_q;
   logic               active_q;
   logic               tx_send_q;
   logic [MSG_W-1:0]   msg_q;
   logic               mode_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [GAP_W-1:0]   gap_q;
   logic [N_REQ-1:0]   ack_q;

   logic [N_REQ-1:0]   eligible;
   logic               found;
   logic [OWNER_W-1:0] win;
   logic [MSG_W-1:0]   sel_msg;
   logic               sel_mode;
   logic [CNT_W-1:0]   sel_cnt;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;
   logic            abort_q;
   logic            err_q;
   logic            wd_hit;

   assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign err    = err_q;
`else
   assign err = 1'b0;
`endif

   // A requester being acked this cycle must not win again immediately.
   assign eligible = req & ~ack_q;

   rr_pick #(
      .N_REQ(N_REQ)
   ) u_pick (
      .eligible(eligible),
      .pointer (ptr_q),
      .found   (found),
      .index   (win)
   );

   assign ptr_d = next_index(win, N_REQ);

   always_comb begin
      sel_msg  = '0;
      sel_mode = 1'b0;
      sel_cnt  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win == OWNER_W'(i)) begin
            sel_msg  = msg_in[i*MSG_W +: MSG_W];
            sel_mode = mode_in[i];
            sel_cnt  = cnt_in[i*CNT_W +: CNT_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         active_q  <= 1'b0;
         tx_send_q <= 1'b0;
         msg_q     <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= '0;
         gap_q     <= '0;
         ack_q     <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         wd_q      <= '0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         ack_q <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  state_q   <= SEND;
                  owner_q   <= win;
                  active_q  <= 1'b1;
                  tx_send_q <= 1'b1;
                  msg_q     <= sel_msg;
                  mode_q    <= sel_mode;
                  cnt_q     <= sel_cnt;
                  ptr_q     <= ptr_d;
`ifdef TX_ARB_TIMEOUT_EN
                  wd_q      <= '0;
                  abort_q   <= 1'b0;
`endif
               end
            end

            SEND: begin
`ifdef TX_ARB_TIMEOUT_EN
               wd_q <= wd_q + 1'b1;
               if (wd_hit) begin
                  tx_send_q <= 1'b0;
                  abort_q   <= 1'b1;
                  state_q   <= GAP;
                  gap_q     <= GAP_W'(GAP_CYCLES);
               end else
`endif
               if (tx_busy) begin
                  tx_send_q <= 1'b0;
                  state_q   <= WAIT;
               end
            end

            WAIT: begin
`ifdef TX_ARB_TIMEOUT_EN
               wd_q <= wd_q + 1'b1;
`endif
               if (!tx_busy) begin
                  if (GAP_CYCLES == 0) begin
                     state_q  <= IDLE;
                     active_q <= 1'b0;
                     ack_q    <= ACK_LSB << owner_q;
`ifdef TX_ARB_TIMEOUT_EN
                     err_q    <= abort_q;
`endif
                  end else begin
                     state_q <= GAP;
                     gap_q   <= GAP_W'(GAP_CYCLES);
                  end
               end
`ifdef TX_ARB_TIMEOUT_EN
               else if (wd_hit) begin
                  abort_q <= 1'b1;
                  state_q <= GAP;
                  gap_q   <= GAP_W'(GAP_CYCLES);
               end
`endif
            end

            GAP: begin
               // Completing on the edge that would reach zero gives exactly
               // GAP_CYCLES idle cycles after the transmitter goes quiet.
               if (gap_q <= 1) begin
                  state_q  <= IDLE;
                  active_q <= 1'b0;
                  ack_q    <= ACK_LSB << owner_q;
`ifdef TX_ARB_TIMEOUT_EN
                  err_q    <= abort_q;
`endif
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack        = ack_q;
   assign owner      = owner_q;
   assign active     = active_q;
   assign tx_send    = tx_send_q;
   assign tx_message = msg_q;
   assign tx_mode    = mode_q;
   assign tx_cnt     = cnt_q;

endmodule

// File: tb/tb_tx_request_arbiter.sv
// Directed self-checking bench for tx_request_arbiter with a small
// transmitter busy model (busy rises 2 cycles after send, holds busy_len).
module tb_tx_request_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  req = '0;
   logic [14:0] msg_in = '0;
   logic [2:0]  mode_in = '0;
   logic [8:0]  cnt_in = '0;
   logic [2:0]  ack;
   logic        err;
   logic [2:0]  owner;
   logic        active;
   logic        tx_send;
   logic [4:0]  tx_message;
   logic        tx_mode;
   logic [2:0]  tx_cnt;
   logic        tx_busy = 1'b0;

   int tests = 0;
   int fails = 0;

   int busy_delay = 2;
   int busy_len   = 100;
   bit model_en   = 1'b1;
   bit busy_force = 1'b0;
   bit busy_run   = 1'b0;
   bit err_seen   = 1'b0;

   always #5 clk = ~clk;

   tx_request_arbiter #(
      .N_REQ         (3),
      .GAP_CYCLES    (16),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .msg_in    (msg_in),
      .mode_in   (mode_in),
      .cnt_in    (cnt_in),
      .ack       (ack),
      .err       (err),
      .owner     (owner),
      .active    (active),
      .tx_send   (tx_send),
      .tx_message(tx_message),
      .tx_mode   (tx_mode),
      .tx_cnt    (tx_cnt),
      .tx_busy   (tx_busy)
   );

   initial begin
      int  d;
      int  h;
      bit  armed;
      d = 0; h = 0; armed = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!model_en) begin
            busy_run = 1'b0;
            armed    = 1'b0;
         end else if (busy_run) begin
            h++;
            if (h >= busy_len) begin
               busy_run = 1'b0;
               armed    = 1'b0;
            end
         end else if (armed) begin
            d++;
            if (d >= busy_delay) begin
               busy_run = 1'b1;
               h        = 0;
            end
         end else if (tx_send === 1'b1) begin
            armed = 1'b1;
            d     = 0;
         end
         tx_busy = model_en ? busy_run : busy_force;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (err === 1'b1) err_seen = 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ack, err, owner, active, tx_send, tx_message, tx_mode, tx_cnt} !== 18'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %b required 0",
                  {ack, err, owner, active, tx_send, tx_message, tx_mode, tx_cnt});
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (active !== 1'b0 || ack !== 3'b000) begin
         fails++;
         $display("FAIL reset_idle: active=%b ack=%b required 0/000", active, ack);
      end
   endtask

   task automatic test_single();
      int n;
      busy_len = 100;
      msg_in[4:0] = 5'b10101;
      mode_in[0]  = 1'b0;
      cnt_in[2:0] = 3'd3;
      req = 3'b001;
      @(negedge clk);
      tests++;
      if (!(active === 1'b1 && tx_send === 1'b1 && owner === 3'd0 &&
            tx_message === 5'b10101 && tx_mode === 1'b0 && tx_cnt === 3'd3)) begin
         fails++;
         $display("FAIL single_grant: active=%b send=%b owner=%0d msg=%b mode=%b cnt=%0d required 1/1/0/10101/0/3",
                  active, tx_send, owner, tx_message, tx_mode, tx_cnt);
      end
      req = 3'b000;
      n = 1;
      while (tx_send === 1'b1 && n < 50) begin
         @(negedge clk);
         if (tx_send === 1'b1) n++;
      end
      tests++;
      if (n !== 3) begin
         fails++;
         $display("FAIL single_send_width: got %0d cycles required 3", n);
      end
      n = 0;
      while (tx_busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (ack === 3'b000 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n !== 17 || ack !== 3'b001 || active !== 1'b0) begin
         fails++;
         $display("FAIL single_ack: got delay=%0d ack=%b active=%b required 17/001/0", n, ack, active);
      end
      @(negedge clk);
      tests++;
      if (ack !== 3'b000 || active !== 1'b0) begin
         fails++;
         $display("FAIL single_ack_pulse: got ack=%b active=%b required 000/0", ack, active);
      end
   endtask

   task automatic test_round_robin();
      int n;
      int acks;
      logic [4:0] exp_msg;
      logic [2:0] exp_cnt;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      busy_len = 10;
      msg_in  = {5'b00100, 5'b00010, 5'b00001};
      cnt_in  = {3'd5, 3'd3, 3'd1};
      mode_in = 3'b010;
      req     = 3'b111;
      acks    = 0;
      for (int k = 0; k < 3; k++) begin
         exp_msg = 5'b00001 << k;
         exp_cnt = 3'(1 + 2 * k);
         n = 0;
         while (active !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         tests++;
         if (owner !== 3'(k) || tx_message !== exp_msg || tx_cnt !== exp_cnt ||
             tx_mode !== (k == 1)) begin
            fails++;
            $display("FAIL rr_grant%0d: owner=%0d msg=%b cnt=%0d mode=%b required %0d/%b/%0d/%b",
                     k, owner, tx_message, tx_cnt, tx_mode, k, exp_msg, exp_cnt, (k == 1));
         end
         n = 0;
         while (ack === 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (ack !== 3'b000) acks++;
         tests++;
         if (ack !== (3'b001 << k)) begin
            fails++;
            $display("FAIL rr_ack%0d: got %b required %b", k, ack, 3'b001 << k);
         end
         req[k] = 1'b0;
         @(negedge clk);
      end
      repeat (30) begin
         if (ack !== 3'b000) acks++;
         @(negedge clk);
      end
      tests++;
      if (acks !== 3) begin
         fails++;
         $display("FAIL rr_ack_count: got %0d required 3", acks);
      end
   endtask

   task automatic test_fairness_wrap();
      int n;
      int order [4];
      int exp_order [4];
      exp_order = '{0, 2, 0, 2};
      busy_len = 10;
      req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (active !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         order[k] = int'(owner);
         n = 0;
         while (ack === 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
         end
         // requester 2 keeps re-requesting through its first ack
         if (k == 0) req[0] = 1'b0;
         if (k == 1) req = 3'b101;
         if (k == 2) req[0] = 1'b0;
         if (k == 3) req[2] = 1'b0;
         if (k == 0) begin
            @(negedge clk);
            req[0] = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (order[k] !== exp_order[k]) begin
            fails++;
            $display("FAIL fair_order%0d: got owner %0d required %0d", k, order[k], exp_order[k]);
         end
      end
      req = 3'b000;
      repeat (30) @(negedge clk);
   endtask

   task automatic test_field_stability();
      int n;
      int bad;
      busy_len = 40;
      msg_in[9:5] = 5'b10101;
      mode_in[1]  = 1'b1;
      cnt_in[5:3] = 3'd6;
      req = 3'b010;
      @(negedge clk);
      tests++;
      if (active !== 1'b1 || owner !== 3'd1 || tx_message !== 5'b10101) begin
         fails++;
         $display("FAIL field_grant: active=%b owner=%0d msg=%b required 1/1/10101", active, owner, tx_message);
      end
      n = 0;
      while (!(tx_send === 1'b0 && tx_busy === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      msg_in[9:5] = 5'b00000;
      mode_in[1]  = 1'b0;
      cnt_in[5:3] = 3'd0;
      bad = 0;
      n = 0;
      while (ack === 3'b000 && n < 200) begin
         @(negedge clk);
         if (tx_message !== 5'b10101 || tx_mode !== 1'b1 || tx_cnt !== 3'd6) bad++;
         n++;
      end
      tests++;
      if (bad !== 0 || ack !== 3'b010) begin
         fails++;
         $display("FAIL field_hold: got %0d bad cycles ack=%b required 0/010", bad, ack);
      end
      req = 3'b000;
      @(negedge clk);
      tests++;
      if (active !== 1'b0) begin
         fails++;
         $display("FAIL field_no_regrant: got active=%b required 0", active);
      end
   endtask

   task automatic test_pending_cancel();
      int n;
      busy_len = 10;
      req = 3'b001;
      @(negedge clk);
      req = 3'b011;
      repeat (4) @(negedge clk);
      req = 3'b101;
      n = 0;
      while (ack === 3'b000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (ack !== 3'b001) begin
         fails++;
         $display("FAIL pend_first_ack: got %b required 001", ack);
      end
      req[0] = 1'b0;
      @(negedge clk);
      tests++;
      if (active !== 1'b1 || owner !== 3'd2) begin
         fails++;
         $display("FAIL pend_waiting_grant: active=%b owner=%0d required 1/2", active, owner);
      end
      n = 0;
      while (ack === 3'b000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      req[2] = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_busy_at_grant();
      int n;
      model_en   = 1'b0;
      busy_force = 1'b1;
      repeat (3) @(negedge clk);
      req = 3'b001;
      @(negedge clk);
      n = 1;
      while (tx_send === 1'b1 && n < 50) begin
         @(negedge clk);
         if (tx_send === 1'b1) n++;
      end
      tests++;
      if (n !== 1) begin
         fails++;
         $display("FAIL busy_grant_send_width: got %0d cycles required 1", n);
      end
      busy_force = 1'b0;
      n = 0;
      while (tx_busy === 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (ack === 3'b000 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n !== 17 || ack !== 3'b001) begin
         fails++;
         $display("FAIL busy_grant_ack: got delay=%0d ack=%b required 17/001", n, ack);
      end
      req = 3'b000;
      model_en = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      int n;
      int bad;
      busy_len = 100;
      req = 3'b001;
      @(negedge clk);
      n = 0;
      while (!(tx_send === 1'b0 && tx_busy === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      req = 3'b000;
      @(negedge clk);
      rst = 1'b1;
      tests++;
      if ({ack, owner, active, tx_send, tx_message, tx_mode, tx_cnt} !== 17'h0) begin
         fails++;
         $display("FAIL midreset_outputs: got %b required 0",
                  {ack, owner, active, tx_send, tx_message, tx_mode, tx_cnt});
      end
      bad = 0;
      repeat (130) begin
         @(negedge clk);
         if (ack !== 3'b000 || active !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL midreset_no_ack: got %0d bad cycles required 0", bad);
      end
   endtask

`ifdef TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      model_en   = 1'b0;
      busy_force = 1'b0;
      repeat (3) @(negedge clk);
      req = 3'b001;
      @(negedge clk);
      req = 3'b000;
      n = 1;
      while (tx_send === 1'b1 && n < 200) begin
         @(negedge clk);
         if (tx_send === 1'b1) n++;
      end
      tests++;
      if (n !== 50) begin
         fails++;
         $display("FAIL timeout_send_width: got %0d cycles required 50", n);
      end
      n = 0;
      while (ack === 3'b000 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n !== 16 || ack !== 3'b001 || err !== 1'b1) begin
         fails++;
         $display("FAIL timeout_err_ack: got delay=%0d ack=%b err=%b required 16/001/1", n, ack, err);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL timeout_err_pulse: got err=%b required 0", err);
      end
      model_en = 1'b1;
   endtask
`else
   task automatic test_timeout();
      tests++;
      if (err_seen !== 1'b0) begin
         fails++;
         $display("FAIL err_tied_low: got err seen=%b required 0", err_seen);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness_wrap();
      test_field_stability();
      test_pending_cancel();
      test_busy_at_grant();
      test_reset_midframe();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
